// File: rtl/dsp_mac_sequencer.sv
// Valid/ready front end that drives a DSP48A1 slice through a multiply-accumulate dot product.
// Define DSP_SEQ_SAT_EN to clamp results to OUT_W bits; otherwise P is returned raw and m_sat stays 0.
module dsp_mac_sequencer #(
  parameter int unsigned DSP_LAT   = 3,
  parameter int unsigned OPM_DLY   = 1,
  parameter logic [7:0]  OPM_FIRST = 8'h01,
  parameter logic [7:0]  OPM_ACC   = 8'h09,
  parameter logic [7:0]  OPM_HOLD  = 8'h08,
  parameter int unsigned OUT_W     = 40
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  input  logic        s_last,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CE,
  output logic        DSP_RST,
  input  logic [47:0] DSP_P,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [47:0] m_data,
  output logic        m_sat
);

  localparam int CNT_W = (DSP_LAT < 1) ? 1 : $clog2(DSP_LAT + 1);

`ifdef DSP_SEQ_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  drain_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept;
  logic              load_ab;
  logic              capture;
  logic [7:0]        opm_push;

  logic [17:0]       a_p0;
  logic [17:0]       b_p0;
  logic [7:0]        opm_p [0:OPM_DLY];
  logic [47:0]       res_p0;
  logic              sat_p0;

  // Returns {clamped_flag, value}; values at or above 2**OUT_W pin to the largest OUT_W-bit code.
  function automatic logic [48:0] clamp_p(input logic [47:0] p);
    logic [48:0] lim;
    lim = 49'd1 << OUT_W;
    if ({1'b0, p} >= lim)
      clamp_p = {1'b1, lim[47:0] - 48'd1};
    else
      clamp_p = {1'b0, p};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = drain_cnt;
    s_ready   = 1'b0;
    accept    = 1'b0;
    load_ab   = 1'b0;
    capture   = 1'b0;
    opm_push  = OPM_HOLD;
    case (state)
      S_IDLE: begin
        s_ready = !RST;
        accept  = s_valid && s_ready;
        if (accept) begin
          load_ab   = 1'b1;
          opm_push  = OPM_FIRST;
          state_nxt = s_last ? S_DRAIN : S_ACCUM;
          cnt_nxt   = CNT_W'(DSP_LAT);
        end
      end
      S_ACCUM: begin
        s_ready = !RST;
        accept  = s_valid && s_ready;
        if (accept) begin
          load_ab  = 1'b1;
          opm_push = OPM_ACC;
          if (s_last) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = CNT_W'(DSP_LAT);
          end
        end
      end
      S_DRAIN: begin
        // The last product reaches P DSP_LAT edges after its accept; sample one edge later.
        if (drain_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = drain_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (m_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: operand registers and the opmode delay line feeding the slice
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_p0 <= '0;
      b_p0 <= '0;
      for (int i = 0; i <= int'(OPM_DLY); i++)
        opm_p[i] <= OPM_HOLD;
    end else begin
      if (load_ab) begin
        a_p0 <= s_a;
        b_p0 <= s_b;
      end
      opm_p[0] <= opm_push;
      for (int i = 1; i <= int'(OPM_DLY); i++)
        opm_p[i] <= opm_p[i-1];
    end
  end

  // Result capture from slice P
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_p0 <= '0;
      sat_p0 <= 1'b0;
    end else if (capture) begin
      {sat_p0, res_p0} <= SAT_EN ? clamp_p(DSP_P) : {1'b0, DSP_P};
    end
  end

  assign DSP_A      = a_p0;
  assign DSP_B      = b_p0;
  assign DSP_OPMODE = opm_p[OPM_DLY];
  assign DSP_CE     = !RST;
  assign DSP_RST    = RST;
  assign m_valid    = (state == S_HOLD);
  assign m_data     = res_p0;
  assign m_sat      = sat_p0;

endmodule
